// File: rtl/uart_out_arbiter.sv
// rtl/uart_out_arbiter.sv - round-robin arbiter of NUM_IN byte streams into a one-entry output buffer
// Optional line locking (one core's line stays contiguous) is enabled by defining UART_ARB_LINE_LOCK_EN.
module uart_out_arbiter #(
   parameter int NUM_IN    = 4,
   parameter int IDX_W     = 2,
   parameter int TIMEOUT   = 1024,
   parameter int TIMEOUT_W = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_IN-1:0]     in_canPeek,
   input  logic [8*NUM_IN-1:0]   in_peek,
   output logic [NUM_IN-1:0]     in_consume_en,
   output logic                  out_canPeek,
   output logic [7:0]            out_peek,
   input  logic                  out_consume_en
);

   localparam logic [7:0] NEWLINE = 8'h0A;

   logic              load;
   logic              grant_valid;
   logic [IDX_W-1:0]  grant_idx;
   logic [7:0]        grant_byte;
   logic [IDX_W-1:0]  ptr;
   logic [IDX_W-1:0]  ptr_next;
   logic [NUM_IN-1:0] eligible;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
      if (int'(i) == NUM_IN - 1)
         return '0;
      else
         return i + IDX_W'(1);
   endfunction

   // The buffer can accept a byte when empty or when its current byte leaves this cycle.
   assign load = ~out_canPeek | out_consume_en;

   always_comb begin
      int               j;
      logic [IDX_W-1:0] cand;
      grant_valid = 1'b0;
      grant_idx   = '0;
      j           = 0;
      cand        = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_IN)
            j = j - NUM_IN;
         cand = IDX_W'(j);
         if (!grant_valid && load && eligible[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   assign grant_byte = in_peek[8*grant_idx +: 8];

`ifdef UART_ARB_LINE_LOCK_EN
   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                 state;
   state_t                 state_next;
   logic [IDX_W-1:0]       owner;
   logic [IDX_W-1:0]       owner_next;
   logic [TIMEOUT_W-1:0]   count;
   logic [TIMEOUT_W-1:0]   count_next;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         owner <= '0;
         count <= '0;
      end else begin
         state <= state_next;
         owner <= owner_next;
         count <= count_next;
      end
   end

   always_comb begin
      state_next = state;
      owner_next = owner;
      count_next = count;
      ptr_next   = ptr;
      case (state)
         IDLE: begin
            if (grant_valid) begin
               ptr_next = wrap_inc(grant_idx);
               if (grant_byte != NEWLINE) begin
                  state_next = LOCKED;
                  owner_next = grant_idx;
                  count_next = '0;
               end
            end
         end
         LOCKED: begin
            if (grant_valid) begin
               count_next = '0;
               if (grant_byte == NEWLINE) begin
                  state_next = IDLE;
                  ptr_next   = wrap_inc(owner);
               end
            end else if (load) begin
               // Only an owner with nothing to send counts as idle; downstream stalls do not.
               if (count == TIMEOUT_W'(TIMEOUT - 2)) begin
                  state_next = IDLE;
                  ptr_next   = wrap_inc(owner);
                  count_next = '0;
               end else begin
                  count_next = count + TIMEOUT_W'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      eligible = in_canPeek;
      if (state == LOCKED) begin
         eligible        = '0;
         eligible[owner] = in_canPeek[owner];
      end
   end
`else
   always_comb begin
      ptr_next = ptr;
      if (grant_valid)
         ptr_next = wrap_inc(grant_idx);
   end

   assign eligible = in_canPeek;
`endif

   always_comb begin
      in_consume_en = '0;
      if (grant_valid && !reset)
         in_consume_en[grant_idx] = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_canPeek <= 1'b0;
         out_peek    <= 8'h00;
         ptr         <= '0;
      end else begin
         ptr <= ptr_next;
         if (grant_valid) begin
            out_canPeek <= 1'b1;
            out_peek    <= grant_byte;
         end else if (out_consume_en) begin
            out_canPeek <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_out_arbiter.sv
// tb/tb_uart_out_arbiter.sv - randomized self-checking bench for uart_out_arbiter against a behavioural model
module tb_uart_out_arbiter;

   localparam int N  = 4;
   localparam int IW = 2;
   localparam int TO = 16;
   localparam int TW = 4;

   logic           clock = 1'b0;
   logic           reset;
   logic [N-1:0]   in_canPeek;
   logic [8*N-1:0] in_peek;
   logic [N-1:0]   in_consume_en;
   logic           out_canPeek;
   logic [7:0]     out_peek;
   logic           out_consume_en;

   int n_cmp = 0;
   int n_bad = 0;

   bit       m_valid;
   bit [7:0] m_byte;
   int       m_ptr;
   bit       m_locked;
   int       m_owner;
   int       m_count;

   always #5 clock = ~clock;

   uart_out_arbiter #(.NUM_IN(N), .IDX_W(IW), .TIMEOUT(TO), .TIMEOUT_W(TW)) dut (
      .clock          (clock),
      .reset          (reset),
      .in_canPeek     (in_canPeek),
      .in_peek        (in_peek),
      .in_consume_en  (in_consume_en),
      .out_canPeek    (out_canPeek),
      .out_peek       (out_peek),
      .out_consume_en (out_consume_en)
   );

   task automatic model_reset();
      m_valid  = 0;
      m_byte   = 8'h00;
      m_ptr    = 0;
      m_locked = 0;
      m_owner  = 0;
      m_count  = 0;
   endtask

   function automatic logic [7:0] rand_byte();
      if ($urandom_range(0, 3) == 0)
         return 8'h0A;
      return 8'($urandom);
   endfunction

   // One clock cycle: drive inputs, check against the model, advance the model, move past the edge.
   task automatic step(input logic [N-1:0] cp, input logic [8*N-1:0] pk, input logic ce,
                       output logic [N-1:0] got);
      logic [N-1:0] exp_ce;
      logic [7:0]   b;
      bit           load;
      int           g;
      in_canPeek     = cp;
      in_peek        = pk;
      out_consume_en = ce;
      #2;
      load = !m_valid || ce;
      g    = -1;
      if (load) begin
         for (int n = 0; n < N; n++) begin
            int c;
            c = (m_ptr + n) % N;
            if (g < 0 && cp[c] && (!m_locked || c == m_owner))
               g = c;
         end
      end
      exp_ce = '0;
      if (g >= 0)
         exp_ce[g] = 1'b1;
      n_cmp++;
      if (in_consume_en !== exp_ce) begin
         n_bad++;
         $display("FAIL consume_en t=%0t got=%b expected=%b", $time, in_consume_en, exp_ce);
      end
      n_cmp++;
      if (out_canPeek !== m_valid) begin
         n_bad++;
         $display("FAIL out_canPeek t=%0t got=%b expected=%b", $time, out_canPeek, m_valid);
      end
      n_cmp++;
      if (out_peek !== m_byte) begin
         n_bad++;
         $display("FAIL out_peek t=%0t got=%h expected=%h", $time, out_peek, m_byte);
      end
      got = in_consume_en;
      if (g >= 0) begin
         b       = pk[8*g +: 8];
         m_valid = 1;
         m_byte  = b;
         if (m_locked) begin
            m_count = 0;
            if (b == 8'h0A) begin
               m_locked = 0;
               m_ptr    = (m_owner + 1) % N;
            end
         end else begin
            m_ptr = (g + 1) % N;
`ifdef UART_ARB_LINE_LOCK_EN
            if (b != 8'h0A) begin
               m_locked = 1;
               m_owner  = g;
               m_count  = 0;
            end
`endif
         end
      end else begin
         if (ce)
            m_valid = 0;
         if (m_locked && load && !cp[m_owner]) begin
            m_count++;
            if (m_count == TO - 1) begin
               m_locked = 0;
               m_ptr    = (m_owner + 1) % N;
               m_count  = 0;
            end
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic drain();
      logic [N-1:0] got;
      for (int i = 0; i < 2; i++)
         step('0, '0, 1'b1, got);
   endtask

   task automatic test_reset();
      reset          = 1'b1;
      in_canPeek     = '1;
      in_peek        = 32'h41424344;
      out_consume_en = 1'b1;
      model_reset();
      #2;
      n_cmp++;
      if (out_canPeek !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_canPeek got=%b expected=0", out_canPeek);
      end
      n_cmp++;
      if (out_peek !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_peek got=%h expected=00", out_peek);
      end
      n_cmp++;
      if (in_consume_en !== '0) begin
         n_bad++;
         $display("FAIL reset_consume got=%b expected=0000", in_consume_en);
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_single_line();
      logic [7:0]     q0[$];
      logic [7:0]     seen[$];
      logic [7:0]     want[3];
      logic [8*N-1:0] pk;
      logic [N-1:0]   got;
      bit             first = 1;
      want = '{8'h48, 8'h69, 8'h0A};
      q0   = '{8'h48, 8'h69, 8'h0A};
      drain();
      for (int i = 0; i < 6; i++) begin
         pk = '0;
         if (q0.size() > 0)
            pk[7:0] = q0[0];
         step({3'b000, q0.size() > 0}, pk, 1'b1, got);
         if (got[0])
            void'(q0.pop_front());
         if (first) begin
            first = 0;
            n_cmp++;
            if (out_canPeek !== 1'b1) begin
               n_bad++;
               $display("FAIL line_latency got=%b expected=1", out_canPeek);
            end
         end
         if (out_canPeek)
            seen.push_back(out_peek);
      end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (i >= seen.size() || seen[i] !== want[i]) begin
            n_bad++;
            $display("FAIL line_byte%0d got=%h expected=%h", i, (i < seen.size()) ? seen[i] : 8'hxx, want[i]);
         end
      end
   endtask

   task automatic test_alternate();
      logic [N-1:0] got;
      logic [N-1:0] prev = '0;
      drain();
      for (int i = 0; i < 12; i++) begin
         step(4'b0101, {8'h33, 8'h32, 8'h31, 8'h30}, 1'b1, got);
         n_cmp++;
         if (!(got == 4'b0001 || got == 4'b0100) || got == prev) begin
            n_bad++;
            $display("FAIL alternate cycle=%0d got=%b previous=%b expected the other of 0001/0100", i, got, prev);
         end
         prev = got;
      end
   endtask

   task automatic test_backpressure();
      logic [N-1:0]   got;
      logic [8*N-1:0] pk;
      logic [7:0]     held;
      step('1, {8'h44, 8'h43, 8'h42, 8'h41}, 1'b1, got);
      held = out_peek;
      for (int i = 0; i < 10; i++) begin
         for (int b = 0; b < N; b++)
            pk[8*b +: 8] = rand_byte();
         step('1, pk, 1'b0, got);
         n_cmp++;
         if (got !== '0 || out_peek !== held) begin
            n_bad++;
            $display("FAIL backpressure cycle=%0d consume=%b peek=%h expected 0000 and %h", i, got, out_peek, held);
         end
      end
      for (int i = 0; i < 4; i++) begin
         step('1, pk, 1'b1, got);
         n_cmp++;
         if ($countones(got) != 1) begin
            n_bad++;
            $display("FAIL resume cycle=%0d consume=%b expected one-hot", i, got);
         end
      end
   endtask

   task automatic test_random();
      logic [N-1:0]   got;
      logic [N-1:0]   cp;
      logic [8*N-1:0] pk;
      for (int i = 0; i < 400; i++) begin
         cp = N'($urandom);
         for (int b = 0; b < N; b++)
            pk[8*b +: 8] = rand_byte();
         step(cp, pk, $urandom_range(0, 3) != 0, got);
      end
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] got;
      for (int i = 0; i < 3; i++)
         step('1, {8'h57, 8'h58, 8'h59, 8'h5A}, 1'b1, got);
      reset = 1'b1;
      #2;
      n_cmp++;
      if (out_canPeek !== 1'b0 || in_consume_en !== '0) begin
         n_bad++;
         $display("FAIL reset_mid canPeek=%b consume=%b expected 0 and 0000", out_canPeek, in_consume_en);
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
      step('1, {8'h57, 8'h58, 8'h59, 8'h5A}, 1'b1, got);
      n_cmp++;
      if (got !== 4'b0001) begin
         n_bad++;
         $display("FAIL reset_mid_first got=%b expected=0001", got);
      end
   endtask

`ifdef UART_ARB_LINE_LOCK_EN
   task automatic test_line_lock();
      logic [7:0]     q0[$];
      logic [7:0]     q1[$];
      logic [7:0]     seen[$];
      logic [7:0]     want[6];
      logic [8*N-1:0] pk;
      logic [N-1:0]   got;
      want = '{8'h41, 8'h42, 8'h0A, 8'h43, 8'h44, 8'h0A};
      q0   = '{8'h41, 8'h42, 8'h0A};
      q1   = '{8'h43, 8'h44, 8'h0A};
      do_reset();
      for (int i = 0; i < 10; i++) begin
         pk = '0;
         if (q0.size() > 0) pk[7:0]  = q0[0];
         if (q1.size() > 0) pk[15:8] = q1[0];
         step({2'b00, q1.size() > 0, q0.size() > 0}, pk, 1'b1, got);
         n_cmp++;
         if (got[1] && q0.size() > 0) begin
            n_bad++;
            $display("FAIL lock_order req1 consumed while req0 line open, consume=%b", got);
         end
         if (got[0]) void'(q0.pop_front());
         if (got[1]) void'(q1.pop_front());
         if (out_canPeek && (got != '0 || q0.size() + q1.size() == 0) && seen.size() < 6)
            seen.push_back(out_peek);
      end
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (i >= seen.size() || seen[i] !== want[i]) begin
            n_bad++;
            $display("FAIL lock_byte%0d got=%h expected=%h", i, (i < seen.size()) ? seen[i] : 8'hxx, want[i]);
         end
      end
   endtask

   task automatic test_timeout();
      logic [N-1:0] got;
      int           hit = -1;
      do_reset();
      step(4'b1001, {8'h33, 8'h00, 8'h00, 8'h41}, 1'b1, got);
      for (int i = 1; i < 40 && hit < 0; i++) begin
         step(4'b1000, {8'h33, 8'h00, 8'h00, 8'h41}, 1'b1, got);
         if (got[3])
            hit = i;
      end
      n_cmp++;
      if (hit != TO) begin
         n_bad++;
         $display("FAIL timeout_grant got=%0d cycles expected=%0d", hit, TO);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_line();
`ifndef UART_ARB_LINE_LOCK_EN
      test_alternate();
`endif
      test_backpressure();
      test_random();
      test_reset_mid();
`ifdef UART_ARB_LINE_LOCK_EN
      test_line_lock();
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
